// File: rtl/food_map_ctrl_pkg.sv
// Shared game constants for the food map: maze geometry, pellet budget, widths and FSM encoding.
package food_map_ctrl_pkg;

    localparam int unsigned MAP_ROWS       = 50;
    localparam int unsigned MAP_COLS       = 80;
    localparam int unsigned MAP_FOOD_TOTAL = 1200;
    localparam int unsigned TILE_PX        = 16;

    localparam int unsigned ROW_W      = 6;
    localparam int unsigned COL_W      = 7;
    localparam int unsigned FOOD_W     = 13;
    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned BCD_DIGITS = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_D_ADDR = 3'd2;
    localparam logic [2:0] ST_D_DATA = 3'd3;
    localparam logic [2:0] ST_E_ADDR = 3'd4;
    localparam logic [2:0] ST_E_DATA = 3'd5;
    localparam logic [2:0] ST_E_WR   = 3'd6;

endpackage

// File: rtl/food_map_ctrl_bcd4_inc.sv
// Four-digit BCD incrementer that sticks at 9999 instead of rolling over.
module bcd4_inc
    import food_map_ctrl_pkg::*;
(
    input  logic [SCORE_W-1:0] in_bcd,
    output logic [SCORE_W-1:0] out_bcd_c
);

    logic carry;

    // Ripple the +1 through the digits, lowest first
    always_comb begin
        out_bcd_c = in_bcd;
        carry     = 1'b1;
        if (in_bcd != SCORE_MAX) begin
            for (int i = 0; i < int'(BCD_DIGITS); i++) begin
                if (carry) begin
                    if (in_bcd[i*4 +: 4] >= 4'd9) begin
                        out_bcd_c[i*4 +: 4] = 4'd0;
                    end else begin
                        out_bcd_c[i*4 +: 4] = in_bcd[i*4 +: 4] + 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/food_map_ctrl.sv
// Food pellet map controller: sole owner of the single-port food RAM, serving display
// row fetches, pacman eat read-modify-writes and level (re)initialisation.
module food_map_ctrl
    import food_map_ctrl_pkg::*;
#(
    parameter int unsigned ROWS       = MAP_ROWS,
    parameter int unsigned COLS       = MAP_COLS,
    parameter int unsigned FOOD_TOTAL = MAP_FOOD_TOTAL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_start,
    output logic               init_busy,
    input  logic               disp_req,
    input  logic [ROW_W-1:0]   disp_row,
    output logic               disp_ack,
    output logic [COLS-1:0]    disp_data,
    input  logic               eat_req,
    input  logic [COL_W-1:0]   eat_x,
    input  logic [ROW_W-1:0]   eat_y,
    output logic               eat_ack,
    output logic               eat_hit,
    output logic [SCORE_W-1:0] score,
    output logic [FOOD_W-1:0]  food_left,
    output logic               level_clear,
    output logic [ROW_W-1:0]   mem_addr,
    output logic               mem_we,
    output logic [COLS-1:0]    mem_wdata,
    input  logic [COLS-1:0]    mem_rdata
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]   ex_q, ex_d;
    logic               init_busy_q, init_busy_d;
    logic               disp_ack_q, disp_ack_d;
    logic [COLS-1:0]    disp_data_q, disp_data_d;
    logic               eat_ack_q, eat_ack_d;
    logic               eat_hit_q, eat_hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FOOD_W-1:0]  food_left_q, food_left_d;
    logic               level_clear_q, level_clear_d;
    logic [ROW_W-1:0]   mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [COLS-1:0]    mem_wdata_q, mem_wdata_d;
    logic [SCORE_W-1:0] score_inc_c;
    logic               ack_hold_c;
    logic               eat_oob_c;

    bcd4_inc u_bcd4_inc (
        .in_bcd    (score_q),
        .out_bcd_c (score_inc_c)
    );

    // An ack still visible means its requester has not dropped yet; skip one IDLE cycle
    assign ack_hold_c = disp_ack_q | eat_ack_q;
    assign eat_oob_c  = (32'(eat_x) >= COLS) || (32'(eat_y) >= ROWS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_d        = ex_q;
        init_busy_d = init_busy_q;
        disp_ack_d  = 1'b0;
        disp_data_d = disp_data_q;
        eat_ack_d   = 1'b0;
        eat_hit_d   = eat_hit_q;
        score_d     = score_q;
        food_left_d = food_left_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d     = ST_INIT;
                    cnt_d       = CNT_W'(1);
                    init_busy_d = 1'b1;
                    mem_addr_d  = '0;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = '1;
                    score_d     = '0;
                    food_left_d = FOOD_W'(FOOD_TOTAL);
                end else if (!ack_hold_c && disp_req) begin
                    state_d    = ST_D_ADDR;
                    mem_addr_d = disp_row;
                end else if (!ack_hold_c && eat_req) begin
                    ex_d = eat_x;
                    if (eat_oob_c) begin
                        eat_ack_d = 1'b1;
                        eat_hit_d = 1'b0;
                    end else begin
                        state_d    = ST_E_ADDR;
                        mem_addr_d = eat_y;
                    end
                end
            end
            // cnt_q is the next row to write; reset enters with it at 0
            ST_INIT: begin
                if (cnt_q == CNT_W'(ROWS)) begin
                    state_d     = ST_IDLE;
                    init_busy_d = 1'b0;
                end else begin
                    mem_addr_d  = ROW_W'(cnt_q);
                    mem_we_d    = 1'b1;
                    mem_wdata_d = '1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            ST_D_ADDR: state_d = ST_D_DATA;
            ST_D_DATA: begin
                state_d     = ST_IDLE;
                disp_data_d = mem_rdata;
                disp_ack_d  = 1'b1;
            end
            ST_E_ADDR: state_d = eat_req ? ST_E_DATA : ST_IDLE;
            ST_E_DATA: begin
                if (eat_req) begin
                    state_d     = ST_E_WR;
                    eat_ack_d   = 1'b1;
                    eat_hit_d   = mem_rdata[ex_q];
                    mem_we_d    = mem_rdata[ex_q];
                    mem_wdata_d = mem_rdata & ~(COLS'(1) << ex_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_E_WR: begin
                state_d = ST_IDLE;
                if (eat_hit_q) begin
                    score_d = score_inc_c;
                    if (food_left_q != '0) begin
                        food_left_d = food_left_q - FOOD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        level_clear_d = (food_left_d == '0) && !init_busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            ex_q          <= '0;
            init_busy_q   <= 1'b1;
            disp_ack_q    <= 1'b0;
            disp_data_q   <= '0;
            eat_ack_q     <= 1'b0;
            eat_hit_q     <= 1'b0;
            score_q       <= '0;
            food_left_q   <= FOOD_W'(FOOD_TOTAL);
            level_clear_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ex_q          <= ex_d;
            init_busy_q   <= init_busy_d;
            disp_ack_q    <= disp_ack_d;
            disp_data_q   <= disp_data_d;
            eat_ack_q     <= eat_ack_d;
            eat_hit_q     <= eat_hit_d;
            score_q       <= score_d;
            food_left_q   <= food_left_d;
            level_clear_q <= level_clear_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign init_busy   = init_busy_q;
    assign disp_ack    = disp_ack_q;
    assign disp_data   = disp_data_q;
    assign eat_ack     = eat_ack_q;
    assign eat_hit     = eat_hit_q;
    assign score       = score_q;
    assign food_left   = food_left_q;
    assign level_clear = level_clear_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_food_map_ctrl.sv
// Scoreboard bench for food_map_ctrl with a behavioural 1-cycle-latency food RAM.
module tb_food_map_ctrl;
    import food_map_ctrl_pkg::*;

    localparam logic [79:0] ONES = '1;

    typedef struct {
        bit          is_eat;
        logic [79:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_start, init_busy;
    logic        disp_req, disp_ack;
    logic [5:0]  disp_row;
    logic [79:0] disp_data;
    logic        eat_req, eat_ack, eat_hit;
    logic [6:0]  eat_x;
    logic [5:0]  eat_y;
    logic [15:0] score;
    logic [12:0] food_left;
    logic        level_clear;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [79:0] mem_wdata, mem_rdata;
    logic [15:0] bcd_in, bcd_out;

    logic [79:0] ram     [0:63];
    logic [79:0] ref_map [0:63];
    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0, bad = 0;
    int          wr_cnt = 0, hit_m = 0;
    logic [15:0] sc_m;
    int          food_m;

    always #5 clk = ~clk;

    food_map_ctrl dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
        .disp_req(disp_req), .disp_row(disp_row), .disp_ack(disp_ack), .disp_data(disp_data),
        .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y), .eat_ack(eat_ack), .eat_hit(eat_hit),
        .score(score), .food_left(food_left), .level_clear(level_clear),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    bcd4_inc u_bcd (.in_bcd(bcd_in), .out_bcd_c(bcd_out));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_model(input logic [15:0] v);
        int n;
        n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
        if (n > 9999) n = 9999;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Acks are matched in order against what the driver predicted, including arrival cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (disp_ack) begin
                if (sb.size() == 0) chk("disp_unexpected", 80'(1), 80'(0));
                else begin
                    e = sb.pop_front();
                    chk("disp_kind", 80'(e.is_eat), 80'(0));
                    chk("disp_cyc", 80'(cyc), 80'(e.cyc));
                    chk("disp_data", disp_data, e.data);
                end
            end
            if (eat_ack) begin
                if (sb.size() == 0) chk("eat_unexpected", 80'(1), 80'(0));
                else begin
                    e = sb.pop_front();
                    chk("eat_kind", 80'(e.is_eat), 80'(1));
                    chk("eat_cyc", 80'(cyc), 80'(e.cyc));
                    chk("eat_hit", 80'(eat_hit), e.data);
                end
            end
            if (mem_we && !init_busy) begin
                wr_cnt++;
                chk("wr_row", mem_wdata, ref_map[mem_addr]);
            end
        end
    end

    task automatic wait_ack(input bit on_eat, input string tag);
        int n = 0;
        while (!(on_eat ? eat_ack : disp_ack) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 80'(on_eat ? eat_ack : disp_ack), 80'(1));
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_score"}, 80'(score), 80'(sc_m));
        chk({tag, "_food"}, 80'(food_left), 80'(food_m));
        chk({tag, "_clear"}, 80'(level_clear), 80'(food_m == 0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 80'(init_busy), 80'(1));
        chk({tag, "_dack"}, 80'(disp_ack), 80'(0));
        chk({tag, "_eack"}, 80'(eat_ack), 80'(0));
        chk({tag, "_ehit"}, 80'(eat_hit), 80'(0));
        chk({tag, "_we"}, 80'(mem_we), 80'(0));
        chk({tag, "_addr"}, 80'(mem_addr), 80'(0));
        chk({tag, "_ddata"}, disp_data, 80'(0));
        chk({tag, "_score"}, 80'(score), 80'(0));
        chk({tag, "_food"}, 80'(food_left), 80'(MAP_FOOD_TOTAL));
        chk({tag, "_clear"}, 80'(level_clear), 80'(0));
    endtask

    // Called on the first negedge of INIT; follows the row sweep to its end
    task automatic watch_init(input string tag);
        int n = 0;
        while (init_busy && n < 100) begin
            chk({tag, "_we"}, 80'(mem_we), 80'(1));
            chk({tag, "_addr"}, 80'(mem_addr), 80'(n));
            chk({tag, "_wdata"}, mem_wdata, ONES);
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 80'(n), 80'(MAP_ROWS));
        for (int r = 0; r < 64; r++) ref_map[r] = (r < int'(MAP_ROWS)) ? ONES : '0;
        sc_m   = '0;
        food_m = int'(MAP_FOOD_TOTAL);
        chk_state(tag);
    endtask

    task automatic do_disp(input int row);
        exp_t e;
        e.is_eat = 1'b0;
        e.data   = ref_map[row];
        e.cyc    = cyc + 3;
        sb.push_back(e);
        disp_row = 6'(row);
        disp_req = 1'b1;
        wait_ack(1'b0, "disp_seen");
        disp_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_eat(input int x, input int y);
        exp_t e;
        bit   inr, hit;
        inr = (x < int'(MAP_COLS)) && (y < int'(MAP_ROWS));
        hit = 1'b0;
        if (inr) begin
            hit = ref_map[y][x];
            ref_map[y][x] = 1'b0;
        end
        if (hit) begin
            sc_m = bcd_model(sc_m);
            if (food_m > 0) food_m--;
            hit_m++;
        end
        e.is_eat = 1'b1;
        e.data   = 80'(hit);
        e.cyc    = cyc + (inr ? 3 : 1);
        sb.push_back(e);
        eat_x   = 7'(x);
        eat_y   = 6'(y);
        eat_req = 1'b1;
        wait_ack(1'b1, "eat_seen");
        eat_req = 1'b0;
        @(negedge clk);
        chk_state("eat");
    endtask

    initial begin : drive
        exp_t        e;
        int          k, wr_before;
        logic [15:0] bcd_tab [8];
        bcd_tab = '{16'h0000, 16'h0009, 16'h0099, 16'h0999, 16'h1299, 16'h4589, 16'h9998, 16'h9999};

        rst_n = 1'b1;
        init_start = 1'b0; disp_req = 1'b0; eat_req = 1'b0;
        disp_row = '0; eat_x = '0; eat_y = '0; bcd_in = '0;
        sc_m = '0; food_m = int'(MAP_FOOD_TOTAL);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        watch_init("rst_init");

        // Single eat hit, repeat miss, and the row readback showing the cleared pellet
        do_disp(3);
        do_eat(5, 3);
        chk("score_one", 80'(score), 80'(16'h0001));
        do_eat(5, 3);
        do_disp(3);

        wr_before = wr_cnt;
        do_eat(80, 0);
        do_eat(0, 50);
        chk("oob_no_write", 80'(wr_cnt), 80'(wr_before));

        // Display and eat raised together: display wins, eat follows after the ack cycle
        k = cyc;
        e.is_eat = 1'b0; e.data = ref_map[3]; e.cyc = k + 3;
        sb.push_back(e);
        e.is_eat = 1'b1; e.data = 80'(ref_map[3][6]); e.cyc = k + 7;
        sb.push_back(e);
        ref_map[3][6] = 1'b0;
        sc_m = bcd_model(sc_m); food_m--; hit_m++;
        disp_row = 6'd3; disp_req = 1'b1;
        eat_x = 7'd6; eat_y = 6'd3; eat_req = 1'b1;
        wait_ack(1'b0, "both_disp_seen");
        disp_req = 1'b0;
        wait_ack(1'b1, "both_eat_seen");
        eat_req = 1'b0;
        @(negedge clk);
        chk_state("both");

        // Restart while a display request is pending: it must wait out the whole INIT
        k = cyc;
        e.is_eat = 1'b0; e.data = ONES; e.cyc = k + int'(MAP_ROWS) + 4;
        sb.push_back(e);
        init_start = 1'b1; disp_row = 6'd0; disp_req = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        watch_init("restart");
        wait_ack(1'b0, "pend_disp_seen");
        disp_req = 1'b0;
        @(negedge clk);

        for (int y = 0; y < 15; y++)
            for (int x = 0; x < int'(MAP_COLS); x++)
                do_eat(x, y);
        chk("cleared", 80'(level_clear), 80'(1));
        do_eat(20, 20);
        chk("food_floor", 80'(food_left), 80'(0));
        do_disp(0);

        foreach (bcd_tab[i]) begin
            bcd_in = bcd_tab[i];
            #1;
            chk("bcd_inc", 80'(bcd_out), 80'(bcd_model(bcd_tab[i])));
        end
        bcd_in = 16'h0099; #1 chk("bcd_0099", 80'(bcd_out), 80'(16'h0100));
        bcd_in = 16'h9999; #1 chk("bcd_sat", 80'(bcd_out), 80'(16'h9999));
        @(negedge clk);

        // Reset lands while the eat RMW sits in E_DATA
        wr_before = wr_cnt;
        eat_x = 7'd10; eat_y = 6'd20; eat_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        eat_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_write", 80'(wr_cnt), 80'(wr_before));
        rst_n = 1'b1;
        @(negedge clk);
        watch_init("abort_init");
        do_disp(20);

        chk("sb_empty", 80'(sb.size()), 80'(0));
        chk("write_count", 80'(wr_cnt), 80'(hit_m));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
